// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: default widths, boot/bubble
// encodings, FSM state encoding and next-PC select codes.
package fetch_stage_pkg;

    localparam int unsigned DEF_VIRT_ADDR_WIDTH = 32;
    localparam int unsigned DEF_INST_WIDTH      = 32;
    localparam logic [31:0] DEF_BOOT_ADDR       = 32'h0000_1000;
    localparam logic [31:0] DEF_NOP_INST        = 32'h0000_0000;

    typedef enum logic {
        FETCH     = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_e;

    // Next-PC select codes driven into fetch_pc_reg
    localparam logic [1:0] PC_SEL_HOLD   = 2'd0;
    localparam logic [1:0] PC_SEL_INC    = 2'd1;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
    localparam logic [1:0] PC_SEL_REDIR  = 2'd3;

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC select (hold / pc+4 / branch target / pending redirect).
// Ports:
//   clk, reset          clock, synchronous active-high reset (pc <= BOOT_ADDR)
//   i_sel               next-PC select code (PC_SEL_*)
//   i_branch_target     redirect target from the ALU stage
//   i_redir_pc          redirect target captured during an i-cache miss
//   o_pc                current PC (registered)
//   o_pc_plus4_c        pc + 4, wraps at 2^VIRT_ADDR_WIDTH (combinational)
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned                VIRT_ADDR_WIDTH = DEF_VIRT_ADDR_WIDTH,
    parameter logic [VIRT_ADDR_WIDTH-1:0] BOOT_ADDR       = VIRT_ADDR_WIDTH'(DEF_BOOT_ADDR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 i_sel,
    input  logic [VIRT_ADDR_WIDTH-1:0] i_branch_target,
    input  logic [VIRT_ADDR_WIDTH-1:0] i_redir_pc,
    output logic [VIRT_ADDR_WIDTH-1:0] o_pc,
    output logic [VIRT_ADDR_WIDTH-1:0] o_pc_plus4_c
);

    logic [VIRT_ADDR_WIDTH-1:0] r_pc;
    logic [VIRT_ADDR_WIDTH-1:0] w_pc_plus4;

    assign w_pc_plus4   = r_pc + VIRT_ADDR_WIDTH'(4);
    assign o_pc         = r_pc;
    assign o_pc_plus4_c = w_pc_plus4;

    // PC update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= BOOT_ADDR;
        end else begin
            case (i_sel)
                PC_SEL_INC:    r_pc <= w_pc_plus4;
                PC_SEL_BRANCH: r_pc <= i_branch_target;
                PC_SEL_REDIR:  r_pc <= i_redir_pc;
                default:       r_pc <= r_pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: owns the PC, issues one i-cache lookup per cycle,
// registers instruction and PC+4 into the fetch/decode register, and handles
// miss waiting, branch redirects and decode stalls.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wrt_en                     fetch/decode register enable
//   branch_taken/target        redirect request and target PC
//   icache_req/addr            lookup request/address (combinational)
//   icache_hit/data            same-cycle hit and instruction word
//   icache_fill_done           one-cycle pulse, miss line filled
//   PCNEXT_FETCH, instruction  registered outputs to decode
//   block_pipe_instr_cache     high while a miss is outstanding
// Optional: `define FETCH_PERF_CNT_EN adds perf_fetched and perf_miss_cycles.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned                VIRT_ADDR_WIDTH = DEF_VIRT_ADDR_WIDTH,
    parameter int unsigned                INST_WIDTH      = DEF_INST_WIDTH,
    parameter logic [VIRT_ADDR_WIDTH-1:0] BOOT_ADDR       = VIRT_ADDR_WIDTH'(DEF_BOOT_ADDR),
    parameter logic [INST_WIDTH-1:0]      NOP_INST        = INST_WIDTH'(DEF_NOP_INST)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrt_en,
    input  logic                       branch_taken,
    input  logic [VIRT_ADDR_WIDTH-1:0] branch_target,
    output logic                       icache_req,
    output logic [VIRT_ADDR_WIDTH-1:0] icache_addr,
    input  logic                       icache_hit,
    input  logic [INST_WIDTH-1:0]      icache_data,
    input  logic                       icache_fill_done,
    output logic [VIRT_ADDR_WIDTH-1:0] PCNEXT_FETCH,
    output logic [INST_WIDTH-1:0]      instruction,
    output logic                       block_pipe_instr_cache
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_miss_cycles
`endif
);

    fetch_state_e               r_state;
    fetch_state_e               w_state_next;
    logic [VIRT_ADDR_WIDTH-1:0] w_pc;
    logic [VIRT_ADDR_WIDTH-1:0] w_pc_plus4;
    logic [1:0]                 w_pc_sel;
    logic [INST_WIDTH-1:0]      r_instruction;
    logic [INST_WIDTH-1:0]      w_instruction_next;
    logic [VIRT_ADDR_WIDTH-1:0] r_pcnext;
    logic [VIRT_ADDR_WIDTH-1:0] w_pcnext_next;
    logic                       r_redir_pend;
    logic                       w_redir_pend_next;
    logic [VIRT_ADDR_WIDTH-1:0] r_redir_pc;
    logic [VIRT_ADDR_WIDTH-1:0] w_redir_pc_next;

    fetch_pc_reg #(
        .VIRT_ADDR_WIDTH (VIRT_ADDR_WIDTH),
        .BOOT_ADDR       (BOOT_ADDR)
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .i_sel           (w_pc_sel),
        .i_branch_target (branch_target),
        .i_redir_pc      (r_redir_pc),
        .o_pc            (w_pc),
        .o_pc_plus4_c    (w_pc_plus4)
    );

    assign icache_req             = 1'b1;
    assign icache_addr            = w_pc;
    assign block_pipe_instr_cache = (r_state == MISS_WAIT);
    assign PCNEXT_FETCH           = r_pcnext;
    assign instruction            = r_instruction;

    // State and pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_instruction <= NOP_INST;
            r_pcnext      <= '0;
            r_redir_pend  <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_instruction <= w_instruction_next;
            r_pcnext      <= w_pcnext_next;
            r_redir_pend  <= w_redir_pend_next;
            r_redir_pc    <= w_redir_pc_next;
        end
    end

    // Next-state, next-PC select and pipeline register inputs
    always_comb begin
        w_state_next       = r_state;
        w_pc_sel           = PC_SEL_HOLD;
        w_instruction_next = r_instruction;
        w_pcnext_next      = r_pcnext;
        w_redir_pend_next  = r_redir_pend;
        w_redir_pc_next    = r_redir_pc;

        case (r_state)
            FETCH: begin
                if (branch_taken) begin
                    // Redirect wins over hit/miss and ignores wrt_en
                    w_pc_sel           = PC_SEL_BRANCH;
                    w_instruction_next = NOP_INST;
                    w_pcnext_next      = '0;
                end else if (icache_hit) begin
                    if (wrt_en) begin
                        w_pc_sel           = PC_SEL_INC;
                        w_instruction_next = icache_data;
                        w_pcnext_next      = w_pc_plus4;
                    end
                end else begin
                    w_state_next = MISS_WAIT;
                    if (wrt_en) begin
                        w_instruction_next = NOP_INST;
                        w_pcnext_next      = '0;
                    end
                end
            end
            MISS_WAIT: begin
                if (wrt_en) begin
                    w_instruction_next = NOP_INST;
                    w_pcnext_next      = '0;
                end
                if (icache_fill_done) begin
                    // A same-cycle branch beats an earlier pending redirect
                    w_state_next      = FETCH;
                    w_redir_pend_next = 1'b0;
                    if (branch_taken) begin
                        w_pc_sel = PC_SEL_BRANCH;
                    end else if (r_redir_pend) begin
                        w_pc_sel = PC_SEL_REDIR;
                    end
                end else if (branch_taken) begin
                    w_redir_pend_next = 1'b1;
                    w_redir_pc_next   = branch_target;
                end
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_hit_accept;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_miss_cycles;

    assign w_hit_accept     = (r_state == FETCH) && !branch_taken && icache_hit && wrt_en;
    assign perf_fetched     = r_perf_fetched;
    assign perf_miss_cycles = r_perf_miss_cycles;

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched     <= '0;
            r_perf_miss_cycles <= '0;
        end else begin
            if (w_hit_accept) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (r_state == MISS_WAIT) begin
                r_perf_miss_cycles <= r_perf_miss_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed scenarios then random stimulus.
module tb_fetch_stage;

    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrt_en = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_hit = 1'b0;
    logic [31:0] icache_data;
    logic        icache_fill_done = 1'b0;
    logic [31:0] PCNEXT_FETCH;
    logic [31:0] instruction;
    logic        block_pipe_instr_cache;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_miss_cycles;
`endif

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign icache_data = mem_word(icache_addr);

    fetch_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .wrt_en                 (wrt_en),
        .branch_taken           (branch_taken),
        .branch_target          (branch_target),
        .icache_req             (icache_req),
        .icache_addr            (icache_addr),
        .icache_hit             (icache_hit),
        .icache_data            (icache_data),
        .icache_fill_done       (icache_fill_done),
        .PCNEXT_FETCH           (PCNEXT_FETCH),
        .instruction            (instruction),
        .block_pipe_instr_cache (block_pipe_instr_cache)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched           (perf_fetched),
        .perf_miss_cycles       (perf_miss_cycles)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        blk;
        logic [31:0] inst;
        logic [31:0] pcn;
        logic [31:0] pf;
        logic [31:0] pm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: architectural view of the fetch stage
    logic [31:0] m_pc, m_rpc, m_inst, m_pcn, m_pf, m_pm;
    bit          m_miss, m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = BOOT; m_miss = 0; m_pend = 0; m_rpc = '0;
        m_inst = NOP; m_pcn = '0; m_pf = '0; m_pm = '0;
    endtask

    // One clock of stimulus; the expected response is queued for the monitor
    task automatic step(input bit rst, input bit hit, input bit wen, input bit br,
                        input logic [31:0] tgt, input bit fill);
        exp_t e;
        @(negedge clk);
        reset = rst; icache_hit = hit; wrt_en = wen;
        branch_taken = br; branch_target = tgt; icache_fill_done = fill;
        e.addr = m_pc;
        e.blk  = m_miss;
        if (rst) begin
            model_reset();
        end else if (!m_miss) begin
            if (br) begin
                m_pc = tgt; m_inst = NOP; m_pcn = '0;
            end else if (hit) begin
                if (wen) begin
                    m_inst = mem_word(m_pc);
                    m_pc   = m_pc + 32'd4;
                    m_pcn  = m_pc;
                    m_pf   = m_pf + 32'd1;
                end
            end else begin
                m_miss = 1;
                if (wen) begin m_inst = NOP; m_pcn = '0; end
            end
        end else begin
            m_pm = m_pm + 32'd1;
            if (wen) begin m_inst = NOP; m_pcn = '0; end
            if (fill) begin
                m_miss = 0;
                if (br)          m_pc = tgt;
                else if (m_pend) m_pc = m_rpc;
                m_pend = 0;
            end else if (br) begin
                m_pend = 1; m_rpc = tgt;
            end
        end
        e.inst = m_inst; e.pcn = m_pcn; e.pf = m_pf; e.pm = m_pm;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs before the edge, registered ones after
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                chk("icache_addr", icache_addr, q[0].addr);
                chk("block_pipe", {31'b0, block_pipe_instr_cache}, {31'b0, q[0].blk});
                chk("icache_req", {31'b0, icache_req}, 32'd1);
                @(posedge clk);
                #1;
                mon_e = q.pop_front();
                chk("instruction", instruction, mon_e.inst);
                chk("PCNEXT_FETCH", PCNEXT_FETCH, mon_e.pcn);
`ifdef FETCH_PERF_CNT_EN
                chk("perf_fetched", perf_fetched, mon_e.pf);
                chk("perf_miss_cycles", perf_miss_cycles, mon_e.pm);
`endif
            end
        end
    end

    initial begin
        bit rst, hit, wen, br, fill;
        logic [31:0] tgt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_instruction", instruction, NOP);
        chk("reset_pcnext", PCNEXT_FETCH, 32'd0);
        chk("reset_addr", icache_addr, BOOT);
        chk("reset_block", {31'b0, block_pipe_instr_cache}, 32'd0);
        model_reset();

        // Four back-to-back hits
        repeat (4) step(0, 1, 1, 0, '0, 0);

        // Miss at 0x1008 with a five-cycle wait
        step(1, 0, 0, 0, '0, 0);
        repeat (2) step(0, 1, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 0);
        repeat (4) step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 1);
        repeat (2) step(0, 1, 1, 0, '0, 0);

        // Branch during a hit at 0x1004
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 1, 0, '0, 0);
        step(0, 1, 1, 1, 32'h0000_2000, 0);
        repeat (2) step(0, 1, 1, 0, '0, 0);

        // Branch mid-miss, later overwritten, then fill
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 1, 32'h0000_5000, 0);
        step(0, 0, 1, 1, 32'h0000_3000, 0);
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 1);
        repeat (2) step(0, 1, 1, 0, '0, 0);

        // Branch in the same cycle as fill overrides the pending redirect
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 1, 32'h0000_6000, 0);
        step(0, 0, 1, 1, 32'h0000_7000, 1);
        step(0, 1, 1, 0, '0, 0);

        // Decode stall for three cycles during hits
        step(0, 1, 1, 0, '0, 0);
        repeat (3) step(0, 1, 0, 0, '0, 0);
        repeat (3) step(0, 1, 1, 0, '0, 0);

        // Reset while waiting on a miss; the later fill pulse is ignored
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 1, 0, '0, 1);
        step(0, 1, 1, 0, '0, 0);

        // PC wrap and unaligned redirect target
        step(0, 1, 1, 1, 32'hFFFF_FFF8, 0);
        repeat (3) step(0, 1, 1, 0, '0, 0);
        step(0, 1, 0, 1, 32'h0000_2002, 0);
        repeat (2) step(0, 1, 1, 0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            hit  = ($urandom_range(0, 3) != 0);
            wen  = ($urandom_range(0, 3) != 0);
            br   = ($urandom_range(0, 9) == 0);
            tgt  = $urandom & 32'h0000_FFFF;
            fill = m_miss ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            step(rst, hit, wen, br, tgt, fill);
        end

        @(negedge clk);
        reset = 0; icache_hit = 0; branch_taken = 0; icache_fill_done = 0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
